vma_seq: RTL and testbench
==========================

// Module: vma_seq
// PURPOSE
//  Sequencer/arbiter for the VMA datapath. Arbitrates trap, operand and instruction-fetch
//  requesters for the single VMA register, then drives the VMA source selects for one load.
//  Also pulses VMA HELD capture, starts and tracks the memory cycle, and loads PC on fetch
//  completion. Sits between MCL/CON-style control and the VMA board.
//  Reports page fail, address-break match and memory-ack timeout as a latched error.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles in WAIT without MEM_ACK/PAGE_FAIL before timeout fault (>=2)
//  CNT_W        5   width of wait counter; must hold ACK_TIMEOUT-1
// PORTS
//  CLK            in   1  clock
//  RESET          in   1  asynchronous, active-high reset
//  FETCH_REQ      in   1  instruction fetch request (VMA <- PC+1), level
//  OPND_REQ       in   1  operand reference request (VMA <- EDP AD), level
//  OPND_WRITE     in   1  operand ref is a write; sampled with grant
//  TRAP_REQ       in   1  trap/magic reference (VMA <- trap mix/magic), level
//  GRANT          out  3  one-hot {TRAP,OPND,FETCH}; 1-cycle pulse
//  VMA_SEL        out  2  VMA reg op: 00 hold, 10 load; 01/11 never driven
//  VMA_AD         out  1  1 = VMA mux takes EDP AD, 0 = VMA adder
//  VMA_INC        out  1  carry-in to VMA adder (PC+1)
//  VMAX_SEL       out  2  section source: 00 VMA, 01 PC, 11 AD (10 prev-sec unused here)
//  LOAD_VMA_HELD  out  1  capture VMA into HELD; 1-cycle pulse
//  LOAD_PC        out  1  load PC from VMA; 1-cycle pulse, fetch only
//  MEM_START      out  1  memory cycle start; 1-cycle pulse
//  MEM_WRITE      out  1  write qualifier; valid with MEM_START
//  MEM_ACK        in   1  memory cycle complete
//  PAGE_FAIL      in   1  pager fault for current reference
//  ADR_BRK_EN     in   1  address-break compare enabled
//  ADR_MATCH      in   1  VMA[13:35] == ADR_BRK[13:35]
//  ERR_CLR        in   1  clears FAULT state
//  BUSY           out  1  1 in any state except IDLE
//  DONE           out  1  1-cycle pulse on good completion
//  ERR            out  2  00 none, 01 page fail, 10 adr break, 11 ack timeout
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. Wait counter 0. RR pointer = OPND.
//    Reset mid-cycle aborts with no further MEM_START.
//  States: IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE; START/WAIT -> FAULT -> IDLE.
//  IDLE: sample requests. TRAP has absolute priority. OPND and FETCH alternate round-robin
//    when both are pending; the pointer flips to the other after each grant to either.
//    On a winner, latch requester and OPND_WRITE, then go to LOAD. No request: stay.
//  LOAD: GRANT[winner]=1, VMA_SEL=10.
//    FETCH: VMA_AD=0, VMA_INC=1, VMAX_SEL=01.
//    OPND: VMA_AD=1, VMA_INC=0, VMAX_SEL=11.
//    TRAP: VMA_AD=0, VMA_INC=0, VMAX_SEL=00.
//    Outside LOAD: VMA_SEL=00, VMA_AD=0, VMA_INC=0, VMAX_SEL=00.
//    Requester may drop its request from the cycle after GRANT.
//  START: LOAD_VMA_HELD=1.
//    If ADR_BRK_EN & ADR_MATCH & requester!=TRAP: go to FAULT, ERR=10, no MEM_START.
//    Otherwise MEM_START=1, MEM_WRITE=latched write (OPND only, else 0), clear counter, go to WAIT.
//  WAIT: counter +1 per cycle.
//    PAGE_FAIL: FAULT with ERR=01. PAGE_FAIL wins over a same-cycle MEM_ACK.
//    Else MEM_ACK: go to DONE.
//    Else counter==ACK_TIMEOUT-1: FAULT with ERR=11.
//    MEM_ACK/PAGE_FAIL outside WAIT are ignored.
//  DONE: DONE=1; LOAD_PC=1 if requester=FETCH; go to IDLE.
//  FAULT: ERR held, BUSY=1, no new grants. ERR_CLR: ERR=00, go to IDLE next cycle.
//  Min latency: req@N, GRANT@N+1, MEM_START@N+2, ACK@N+3, DONE@N+4, next grant@N+6.
// TESTING
//  FETCH_REQ alone, ACK 1 cycle after MEM_START -> GRANT=001@N+1 with VMA_INC=1,
//    VMAX_SEL=01; DONE and LOAD_PC @N+4.
//  OPND_REQ+FETCH_REQ held, 4 transactions -> grants OPND,FETCH,OPND,FETCH.
//    MEM_WRITE follows OPND_WRITE on OPND only.
//  TRAP_REQ with OPND+FETCH pending -> GRANT=100 first; RR pointer unchanged afterwards.
//  ADR_BRK_EN=1, ADR_MATCH=1 on OPND -> no MEM_START; ERR=10. ERR_CLR -> IDLE.
//    Same with TRAP -> normal completion.
//  PAGE_FAIL and MEM_ACK same cycle -> ERR=01, no DONE.
//    No ack for 16 WAIT cycles -> ERR=11.
//  RESET asserted during WAIT -> all outputs 0 immediately; next request regranted from IDLE.

Source files
------------

// File: rtl/vma_seq.sv
// VMA sequencer: arbitrates trap/operand/fetch references for the single VMA register,
// steers the VMA source selects for one load, runs the memory cycle and latches faults.
module vma_seq #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic             opnd_req,
    input  logic             opnd_write,
    input  logic             trap_req,
    output logic [2:0]       grant,
    output logic [1:0]       vma_sel,
    output logic             vma_ad,
    output logic             vma_inc,
    output logic [1:0]       vmax_sel,
    output logic             load_vma_held,
    output logic             load_pc,
    output logic             mem_start,
    output logic             mem_write,
    input  logic             mem_ack,
    input  logic             page_fail,
    input  logic             adr_brk_en,
    input  logic             adr_match,
    input  logic             err_clr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StDone,
        StFault
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(ACK_TIMEOUT - 1);

    state_e           state_q;
    logic [2:0]       req_q;      // one-hot {trap, opnd, fetch} of the current owner
    logic             wr_q;
    logic             rr_opnd_q;  // 1: operand wins the next opnd/fetch tie
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       grant_q;
    logic [1:0]       vma_sel_q;
    logic             vma_ad_q;
    logic             vma_inc_q;
    logic [1:0]       vmax_sel_q;
    logic             held_q;
    logic             load_pc_q;
    logic             done_q;
    logic             busy_q;
    logic [1:0]       err_q;

    logic [2:0]       win;
    logic             brk_hit;

    always_comb begin
        win = 3'b000;
        if (trap_req) begin
            win = 3'b100;
        end else if (opnd_req && fetch_req) begin
            win = rr_opnd_q ? 3'b010 : 3'b001;
        end else if (opnd_req) begin
            win = 3'b010;
        end else if (fetch_req) begin
            win = 3'b001;
        end
    end

    // Address break compares the freshly loaded VMA, so it can only be judged in START.
    assign brk_hit = adr_brk_en & adr_match & ~req_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 3'b000;
            wr_q       <= 1'b0;
            rr_opnd_q  <= 1'b1;
            cnt_q      <= '0;
            grant_q    <= 3'b000;
            vma_sel_q  <= 2'b00;
            vma_ad_q   <= 1'b0;
            vma_inc_q  <= 1'b0;
            vmax_sel_q <= 2'b00;
            held_q     <= 1'b0;
            load_pc_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            grant_q    <= 3'b000;
            vma_sel_q  <= 2'b00;
            vma_ad_q   <= 1'b0;
            vma_inc_q  <= 1'b0;
            vmax_sel_q <= 2'b00;
            held_q     <= 1'b0;
            load_pc_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (|win) begin
                        req_q     <= win;
                        wr_q      <= win[1] & opnd_write;
                        if (!win[2]) begin
                            rr_opnd_q <= win[0];
                        end
                        grant_q   <= win;
                        vma_sel_q <= 2'b10;
                        vma_ad_q  <= win[1];
                        vma_inc_q <= win[0];
                        vmax_sel_q <= win[0] ? 2'b01 : (win[1] ? 2'b11 : 2'b00);
                        busy_q    <= 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    held_q  <= 1'b1;
                    state_q <= StStart;
                end
                StStart: begin
                    if (brk_hit) begin
                        err_q   <= 2'b10;
                        state_q <= StFault;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (page_fail) begin
                        err_q   <= 2'b01;
                        state_q <= StFault;
                    end else if (mem_ack) begin
                        done_q    <= 1'b1;
                        load_pc_q <= req_q[0];
                        state_q   <= StDone;
                    end else if (cnt_q == CntMax) begin
                        err_q   <= 2'b11;
                        state_q <= StFault;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StFault: begin
                    if (err_clr) begin
                        err_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign vma_sel       = vma_sel_q;
    assign vma_ad        = vma_ad_q;
    assign vma_inc       = vma_inc_q;
    assign vmax_sel      = vmax_sel_q;
    assign load_vma_held = held_q;
    assign load_pc       = load_pc_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign err           = err_q;
    // Start is suppressed in the same cycle an address break is detected.
    assign mem_start     = (state_q == StStart) & ~brk_hit;
    assign mem_write     = mem_start & wr_q;

endmodule

// File: tb/tb_vma_seq.sv
// Bench for vma_seq: directed and randomized references checked cycle by cycle against a
// transaction-level model of arbitration, latency and fault reporting.
module tb_vma_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req, opnd_req, opnd_write, trap_req;
    logic [2:0] grant;
    logic [1:0] vma_sel;
    logic       vma_ad, vma_inc;
    logic [1:0] vmax_sel;
    logic       load_vma_held, load_pc, mem_start, mem_write;
    logic       mem_ack, page_fail, adr_brk_en, adr_match, err_clr;
    logic       busy, done;
    logic [1:0] err;

    int checks   = 0;
    int failures = 0;
    bit pref_opnd;  // model: operand wins the next opnd/fetch tie

    always #5 clk = ~clk;

    vma_seq #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .opnd_req(opnd_req), .opnd_write(opnd_write),
        .trap_req(trap_req), .grant(grant), .vma_sel(vma_sel), .vma_ad(vma_ad),
        .vma_inc(vma_inc), .vmax_sel(vmax_sel), .load_vma_held(load_vma_held),
        .load_pc(load_pc), .mem_start(mem_start), .mem_write(mem_write),
        .mem_ack(mem_ack), .page_fail(page_fail), .adr_brk_en(adr_brk_en),
        .adr_match(adr_match), .err_clr(err_clr), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [2:0] pick(input bit t, input bit o, input bit f);
        if (t) return 3'b100;
        if (o && f) return pref_opnd ? 3'b010 : 3'b001;
        if (o) return 3'b010;
        if (f) return 3'b001;
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic clr_inputs;
        fetch_req = 0; opnd_req = 0; opnd_write = 0; trap_req = 0;
        mem_ack = 0; page_fail = 0; adr_brk_en = 0; adr_match = 0; err_clr = 0;
    endtask

    // kind: 0 = ack in WAIT cycle dly, 1 = page fail together with ack, 2 = no ack (timeout)
    task automatic txn(input bit t, input bit o, input bit f, input bit w,
                       input bit be, input bit bm, input int kind, input int dly);
        logic [2:0] g;
        bit brk;
        trap_req = t; opnd_req = o; fetch_req = f; opnd_write = w;
        adr_brk_en = be; adr_match = bm;
        g = pick(t, o, f);
        chk("idle_busy", 4'(busy), 4'd0);
        step;
        chk("grant", 4'(grant), 4'(g));
        chk("load_vma_sel", 4'(vma_sel), 4'b0010);
        chk("load_vma_ad", 4'(vma_ad), 4'(g[1]));
        chk("load_vma_inc", 4'(vma_inc), 4'(g[0]));
        chk("load_vmax_sel", 4'(vmax_sel), g[0] ? 4'd1 : (g[1] ? 4'd3 : 4'd0));
        chk("load_busy", 4'(busy), 4'd1);
        chk("load_no_start", 4'(mem_start), 4'd0);
        if (!g[2]) pref_opnd = g[0];
        trap_req = 0; opnd_req = 0; fetch_req = 0; opnd_write = 0;
        mem_ack = 1'($urandom_range(0, 1));  // stray ack outside WAIT must be ignored
        step;
        mem_ack = 0;
        brk = be && bm && !g[2];
        chk("start_held", 4'(load_vma_held), 4'd1);
        chk("start_grant_off", 4'(grant), 4'd0);
        chk("start_vma_sel", 4'(vma_sel), 4'd0);
        chk("start_mem_start", 4'(mem_start), 4'(!brk));
        chk("start_mem_write", 4'(mem_write), 4'(!brk && g[1] && w));
        if (brk) begin
            step;
            chk("brk_err", 4'(err), 4'd2);
            chk("brk_busy", 4'(busy), 4'd1);
            chk("brk_no_start", 4'(mem_start), 4'd0);
            step;
            chk("brk_err_hold", 4'(err), 4'd2);
            err_clr = 1;
            step;
            err_clr = 0;
            chk("brk_clr_err", 4'(err), 4'd0);
            chk("brk_clr_busy", 4'(busy), 4'd0);
            return;
        end
        for (int i = 0; i < 16; i++) begin
            step;
            chk("wait_busy", 4'(busy), 4'd1);
            chk("wait_done", 4'(done), 4'd0);
            chk("wait_err", 4'(err), 4'd0);
            chk("wait_start", 4'(mem_start), 4'd0);
            if (kind != 2 && i == dly) begin
                mem_ack = 1;
                page_fail = (kind == 1);
                break;
            end
        end
        step;
        mem_ack = 0; page_fail = 0;
        if (kind == 0) begin
            chk("done", 4'(done), 4'd1);
            chk("load_pc", 4'(load_pc), 4'(g[0]));
            chk("done_err", 4'(err), 4'd0);
            step;
            chk("post_done", 4'(done), 4'd0);
            chk("post_load_pc", 4'(load_pc), 4'd0);
            chk("post_busy", 4'(busy), 4'd0);
        end else begin
            chk("fault_err", 4'(err), (kind == 1) ? 4'd1 : 4'd3);
            chk("fault_no_done", 4'(done), 4'd0);
            chk("fault_busy", 4'(busy), 4'd1);
            err_clr = 1;
            step;
            err_clr = 0;
            chk("fault_clr_err", 4'(err), 4'd0);
            chk("fault_clr_busy", 4'(busy), 4'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit t, o, f;
        clr_inputs();
        rst = 1;
        pref_opnd = 1;
        step;
        step;
        chk("rst_grant", 4'(grant), 4'd0);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_err", 4'(err), 4'd0);
        chk("rst_start", 4'(mem_start), 4'd0);
        chk("rst_vma_sel", 4'(vma_sel), 4'd0);
        rst = 0;
        step;
        step;
        chk("idle_no_grant", 4'(grant), 4'd0);

        txn(0, 0, 1, 0, 0, 0, 0, 0);                    // fetch alone, minimum latency
        for (int k = 0; k < 4; k++)                     // opnd/fetch alternate
            txn(0, 1, 1, 1'($urandom_range(0, 1)), 0, 0, 0, int'($urandom_range(0, 4)));
        txn(1, 1, 1, 1, 0, 0, 0, 1);                    // trap first, pointer untouched
        txn(0, 1, 1, 1, 0, 0, 0, 0);
        txn(0, 1, 0, 1, 1, 1, 0, 0);                    // address break on operand
        txn(1, 0, 0, 0, 1, 1, 0, 2);                    // trap ignores address break
        txn(0, 0, 1, 0, 0, 0, 1, 3);                    // page fail beats same-cycle ack
        txn(0, 1, 0, 0, 0, 0, 2, 0);                    // ack timeout
        txn(0, 0, 1, 0, 0, 0, 0, 15);                   // ack on last allowed cycle

        // Reset in the middle of WAIT
        opnd_req = 1;
        step;
        opnd_req = 0;
        pref_opnd = 0;
        step;
        step;
        rst = 1;
        #1;
        chk("mid_rst_busy", 4'(busy), 4'd0);
        chk("mid_rst_start", 4'(mem_start), 4'd0);
        chk("mid_rst_grant", 4'(grant), 4'd0);
        chk("mid_rst_done", 4'(done), 4'd0);
        chk("mid_rst_held", 4'(load_vma_held), 4'd0);
        pref_opnd = 1;
        step;
        rst = 0;
        step;
        chk("post_rst_start", 4'(mem_start), 4'd0);
        txn(0, 1, 1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            t = 1'($urandom_range(0, 3) == 0);
            o = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            if (!t && !o && !f) f = 1;
            txn(t, o, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
